// File: rtl/fmt_receiver.sv
// rtl/fmt_receiver.sv - packet receiver with length checking and FWFT packet buffer
module fmt_receiver #(
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fmt_req_i,
  input  logic [1:0]               fmt_child_i,
  input  logic [5:0]               fmt_length_i,
  input  logic [31:0]              fmt_data_i,
  input  logic                     fmt_start_i,
  input  logic                     fmt_end_i,
  output logic                     fmt_grant_o,
  output logic [31:0]              out_data_o,
  output logic [1:0]               out_id_o,
  output logic                     out_sop_o,
  output logic                     out_eop_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     len_err_o,
  output logic [7:0]               err_cnt_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT, RECV} state_t;

  state_t        state, state_nxt;
  logic [5:0]    len_q;
  logic [1:0]    id_q;
  logic          active_q;
  logic [5:0]    wcnt_q;
  logic [5:0]    wcnt_nxt;
  logic          len_err_q;
  logic [7:0]    err_cnt_q;

  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [35:0]   head;

  logic          legal, hit, accept, illegal, wr_en, exit_pkt, rd_en, len_err_d, eop;

  assign legal    = (fmt_length_i == 6'd4) || (fmt_length_i == 6'd8) ||
                    (fmt_length_i == 6'd16) || (fmt_length_i == 6'd32);
  assign wcnt_nxt = fmt_start_i ? 6'd1 : wcnt_q + 6'd1;
  assign hit      = (wcnt_nxt == len_q);
  assign eop      = fmt_end_i | hit;
  // A packet closes on either its end marker or on reaching the granted length;
  // it is a mismatch whenever exactly one of the two happens on that word.
  assign len_err_d = illegal | (exit_pkt & (fmt_end_i ^ hit));

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    wr_en     = 1'b0;
    exit_pkt  = 1'b0;
    case (state)
      IDLE: begin
        if (fmt_req_i) begin
          if (!legal) begin
            illegal = 1'b1;
          end else if (free_o >= (AW + 1)'(fmt_length_i)) begin
            accept    = 1'b1;
            state_nxt = GRANT;
          end
        end
      end
      GRANT: state_nxt = RECV;
      RECV: begin
        if (fmt_start_i || active_q) begin
          wr_en = 1'b1;
          if (fmt_end_i || hit) begin
            exit_pkt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, latched request fields, word counter and error reporting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      len_q     <= '0;
      id_q      <= '0;
      active_q  <= 1'b0;
      wcnt_q    <= '0;
      len_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      len_err_q <= len_err_d;
      if (accept) begin
        len_q <= fmt_length_i;
        id_q  <= fmt_child_i;
      end
      if (exit_pkt) begin
        active_q <= 1'b0;
      end else if (wr_en) begin
        active_q <= 1'b1;
      end
      if (wr_en) begin
        wcnt_q <= wcnt_nxt;
      end
      if (len_err_d && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Buffer storage; contents need no reset because outputs are gated by occupancy
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= {fmt_data_i, id_q, fmt_start_i, eop};
    end
  end

  assign rd_en = out_valid_o & out_ready_i;

  // Circular pointers and occupancy count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Space is reserved at grant time, so a write into a full buffer means a logic bug
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(wr_en && count == (AW + 1)'(DEPTH)));
    end
  end

  assign head        = mem[rd_ptr];
  assign out_valid_o = (count != '0);
  assign out_data_o  = out_valid_o ? head[35:4] : '0;
  assign out_id_o    = out_valid_o ? head[3:2]  : '0;
  assign out_sop_o   = out_valid_o & head[1];
  assign out_eop_o   = out_valid_o & head[0];
  assign free_o      = (AW + 1)'(DEPTH) - count;
  assign fmt_grant_o = (state == GRANT);
  assign len_err_o   = len_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_fmt_receiver.sv
// tb/tb_fmt_receiver.sv - self-checking bench for fmt_receiver
module tb_fmt_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        fmt_req;
  logic [1:0]  fmt_child;
  logic [5:0]  fmt_length;
  logic [31:0] fmt_data;
  logic        fmt_start;
  logic        fmt_end;
  logic        fmt_grant;
  logic [31:0] out_data;
  logic [1:0]  out_id;
  logic        out_sop;
  logic        out_eop;
  logic        out_valid;
  logic        out_ready;
  logic        len_err;
  logic [7:0]  err_cnt;
  logic [6:0]  free;

  int checks   = 0;
  int failures = 0;
  int err_model = 0;
  logic [35:0] exp_q[$];

  fmt_receiver #(.DEPTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .fmt_req_i(fmt_req), .fmt_child_i(fmt_child),
    .fmt_length_i(fmt_length), .fmt_data_i(fmt_data), .fmt_start_i(fmt_start),
    .fmt_end_i(fmt_end), .fmt_grant_o(fmt_grant), .out_data_o(out_data),
    .out_id_o(out_id), .out_sop_o(out_sop), .out_eop_o(out_eop),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .len_err_o(len_err),
    .err_cnt_o(err_cnt), .free_o(free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output scoreboard: every accepted word must match the next expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_extra_word", out_valid, 1'b0);
      end else begin
        chk("out_word", {out_data, out_id, out_sop, out_eop}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic request(input logic [1:0] child, input logic [5:0] len,
                         input int limit, output bit got);
    fmt_req = 1'b1; fmt_child = child; fmt_length = len; got = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      @(posedge clk); #1;
      if (fmt_grant) got = 1'b1;
    end
    fmt_req = 1'b0;
  endtask

  task automatic send_words(input logic [1:0] child, input int len, input int n,
                            input bit rnd_ready);
    int exit_idx;
    bit exp_err;
    logic [31:0] d;
    fmt_data = $urandom; fmt_start = 1'b1; fmt_end = 1'b1;
    @(posedge clk); #1;
    chk("grant_one_cycle", fmt_grant, 1'b0);
    exit_idx = (n < len) ? n - 1 : len - 1;
    exp_err  = (n != len);
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      fmt_data = d; fmt_start = (i == 0); fmt_end = (i == n - 1);
      if (rnd_ready) out_ready = $urandom_range(0, 1);
      if (i <= exit_idx) exp_q.push_back({d, child, i == 0, i == exit_idx});
      @(posedge clk); #1;
      if (i == exit_idx) begin
        if (exp_err && err_model < 255) err_model++;
        chk("len_err_at_close", len_err, exp_err);
        chk("err_cnt_at_close", err_cnt, err_model);
      end
    end
    fmt_start = 1'b0; fmt_end = 1'b0; fmt_data = '0;
    @(posedge clk); #1;
    chk("len_err_single", len_err, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 500 && (exp_q.size() != 0 || out_valid); c++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_free_full", free, 64);
  endtask

  task automatic illegal_req();
    logic [5:0] l;
    l = 6'($urandom_range(0, 63));
    while (l == 4 || l == 8 || l == 16 || l == 32) l = 6'($urandom_range(0, 63));
    fmt_req = 1'b1; fmt_length = l; fmt_child = 2'($urandom);
    @(posedge clk); #1;
    fmt_req = 1'b0;
    if (err_model < 255) err_model++;
    chk("illegal_no_grant", fmt_grant, 1'b0);
    chk("illegal_len_err", len_err, 1'b1);
    chk("illegal_err_cnt", err_cnt, err_model);
  endtask

  initial begin
    bit got;
    int len, n;
    logic [35:0] held;
    rst = 1'b1; fmt_req = 0; fmt_child = 0; fmt_length = 0; fmt_data = 0;
    fmt_start = 0; fmt_end = 0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_free", free, 64);
    chk("rst_grant", fmt_grant, 1'b0);
    chk("rst_outs", {out_data, out_id, out_sop, out_eop, len_err, err_cnt}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Basic 8-word packet on channel 2
    request(2'd2, 6'd8, 10, got);
    chk("basic_grant", got, 1'b1);
    send_words(2'd2, 8, 8, 1'b0);
    drain();

    // Early end: length 8, end on word 6
    request(2'd1, 6'd8, 10, got);
    chk("early_grant", got, 1'b1);
    send_words(2'd1, 8, 6, 1'b0);
    drain();

    // Illegal length 5
    fmt_req = 1'b1; fmt_length = 6'd5;
    @(posedge clk); #1;
    fmt_req = 1'b0; err_model++;
    chk("len5_no_grant", fmt_grant, 1'b0);
    chk("len5_len_err", len_err, 1'b1);
    chk("len5_err_cnt", err_cnt, err_model);
    @(posedge clk); #1;
    chk("len5_len_err_pulse", len_err, 1'b0);

    // Fill the buffer with four 16-word packets while the sink stalls
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      request(2'(p), 6'd16, 10, got);
      chk("fill_grant", got, 1'b1);
      send_words(2'(p), 16, 16, 1'b0);
      chk("fill_free", free, 48 - 16 * p);
    end
    held = {out_data, out_id, out_sop, out_eop};
    fmt_req = 1'b1; fmt_length = 6'd16; fmt_child = 2'd3;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("full_no_grant", fmt_grant, 1'b0);
      chk("stall_head_stable", {out_data, out_id, out_sop, out_eop}, held);
    end
    out_ready = 1'b1;
    request(2'd3, 6'd16, 40, got);
    chk("full_grant_after_drain", got, 1'b1);
    send_words(2'd3, 16, 16, 1'b0);
    drain();

    // Random legal packets with length mismatches and a bursty sink
    for (int p = 0; p < 8; p++) begin
      len = 4 << $urandom_range(0, 3);
      n = len + $urandom_range(0, 3) - 2;
      request(2'($urandom), 6'(len), 10, got);
      chk("rand_grant", got, 1'b1);
      send_words(fmt_child, len, n, 1'b1);
      out_ready = 1'b1;
    end
    drain();

    // Reset in the middle of a 16-word packet
    out_ready = 1'b0;
    request(2'd1, 6'd16, 10, got);
    chk("rst_mid_grant", got, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      fmt_data = $urandom; fmt_start = (i == 0);
      @(posedge clk); #1;
    end
    fmt_data = $urandom; fmt_start = 1'b0;
    #2; rst = 1'b1; #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_free", free, 64);
    chk("rst_mid_outs", {out_data, out_id, out_sop, out_eop, fmt_grant, len_err, err_cnt}, '0);
    exp_q.delete(); err_model = 0;
    @(posedge clk); #1;
    rst = 1'b0; fmt_data = '0; out_ready = 1'b1;
    request(2'd0, 6'd4, 10, got);
    chk("post_rst_grant", got, 1'b1);
    send_words(2'd0, 4, 4, 1'b0);
    drain();

    // Error counter saturation
    for (int k = 0; k < 300; k++) illegal_req();
    chk("err_cnt_saturated", err_cnt, 255);

    // Back-to-back 32-word packets wrap the pointers
    for (int p = 0; p < 5; p++) begin
      request(2'(p), 6'd32, 10, got);
      chk("b2b_grant", got, 1'b1);
      send_words(2'(p), 32, 32, 1'b0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
